// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Reads a burst of consecutive words from a single-port, write-first block RAM
//   (1-cycle read latency) and streams them out through a 2-entry FIFO with
//   valid/ready handshake. A side write channel shares the RAM port; reads have
//   priority and writes are granted in every cycle without a read.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start, base_addr, count burst request; base_addr/count sampled with start
//   busy, done              burst active / one-cycle completion pulse
//   out_valid, out_ready,   stream output; out_last marks the final word
//   out_data, out_last
//   wr_req, wr_addr,        side write channel; wr_ack is combinational grant
//   wr_data, wr_ack
//   ram_en, ram_we,         block RAM port
//   ram_addr, ram_di, ram_dout

module ram_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_di,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam logic [ADDR_WIDTH:0] RemOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  done_q, done_d;
    // A read issued last cycle whose data is on ram_dout now
    logic                  inflight_q, inflight_last_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic                  fifo_last_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            fifo_cnt_q;

    logic issue, last_issue, push, pop, wr_grant;

    // Credit check: buffered words plus the word in flight must leave room.
    assign issue      = (state_q == StRun) && ((fifo_cnt_q + {1'b0, inflight_q}) < 2'd2);
    assign last_issue = issue && (remaining_q == RemOne);
    assign push       = inflight_q;
    assign pop        = out_valid && out_ready;
    // Gated by rst_n so no write is granted while the block is held in reset.
    assign wr_grant   = rst_n && wr_req && !issue;

    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = done_q;
    assign out_valid = (fifo_cnt_q != 2'd0);
    assign out_data  = fifo_data_q[rd_ptr_q];
    assign out_last  = out_valid && fifo_last_q[rd_ptr_q];
    assign wr_ack    = wr_grant;

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        if (issue) begin
            ram_en   = 1'b1;
            ram_addr = addr_q;
        end else if (wr_grant) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wr_addr;
            ram_di   = wr_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (count != '0) begin
                        addr_d      = base_addr;
                        remaining_d = count;
                        state_d     = StRun;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (issue) begin
                    addr_d      = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    remaining_d = remaining_q - RemOne;
                    if (last_issue) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if ((fifo_cnt_q == 2'd0) && !inflight_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            remaining_q     <= '0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            done_q          <= done_d;
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
        end
    end

    // Only reads set inflight_q, so the write-first echo is never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= ram_dout;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 2'd1;
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: behavioural write-first RAM preloaded
// with mem[i]=i, scoreboards for stream words and read addresses.
module tb_ram_stream_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] count;
    logic       busy, done;
    logic       out_valid, out_ready, out_last;
    logic [7:0] out_data;
    logic       wr_req, wr_ack;
    logic [7:0] wr_addr, wr_data;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_di, ram_dout;

    int n_checks = 0;
    int n_fail   = 0;
    int reads_issued = 0;
    int grants = 0;
    int done_count = 0;

    logic [8:0] exp_q [$];     // {last, data}
    logic [7:0] addr_q [$];

    logic [7:0] mem [256];
    bit         mem_init = 1'b0;

    ram_stream_reader #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_di   (ram_di),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first single-port RAM, 1-cycle read latency
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            mem_init <= 1'b1;
            ram_dout <= 8'h00;
        end else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_di;
                ram_dout      <= ram_di;
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitors
    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                check("stream_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("stream_data", out_data, e[7:0]);
                    check("stream_last", out_last, e[8]);
                end
            end
            if (prev_valid && !prev_ready) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            if (ram_en && !ram_we) begin
                reads_issued++;
                check("read_pending", 32'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0) check("read_addr", ram_addr, addr_q.pop_front());
            end
            if (wr_ack) begin
                grants++;
                check("wr_en", ram_en, 1);
                check("wr_we", ram_we, 1);
                check("wr_addr", ram_addr, wr_addr);
                check("wr_di", ram_di, wr_data);
            end else if (wr_req) begin
                check("wr_blocked_by_read", 32'(ram_en && !ram_we), 1);
            end
            if (done) done_count++;
        end
    end

    task automatic do_start(input logic [7:0] b, input logic [8:0] c, input bit expect_it);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        count = c;
        if (expect_it) begin
            for (int i = 0; i < int'(c); i++) begin
                logic [7:0] a;
                logic       lst;
                a   = b + 8'(i);
                lst = (i == int'(c) - 1);
                exp_q.push_back({lst, a});
                addr_q.push_back(a);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int n = 0;
        @(negedge clk);
        while (!done && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done, 1);
        @(negedge clk);
        check({tag, "_done_once"}, done, 0);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_words_left"}, exp_q.size(), 0);
        check({tag, "_reads_left"}, addr_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, done, 0);
        check({p, "_out_valid"}, out_valid, 0);
        check({p, "_out_last"}, out_last, 0);
        check({p, "_out_data"}, out_data, 0);
        check({p, "_ram_en"}, ram_en, 0);
        check({p, "_ram_we"}, ram_we, 0);
        check({p, "_ram_addr"}, ram_addr, 0);
        check({p, "_ram_di"}, ram_di, 0);
        check({p, "_wr_ack"}, wr_ack, 0);
    endtask

    initial begin
        int d0, r0, g0;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = 8'h00;
        count = 9'd0;
        out_ready = 1'b1;
        // Write request during reset must not be granted
        wr_req = 1'b1;
        wr_addr = 8'h80;
        wr_data = 8'h5A;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        wr_req = 1'b0;
        rst_n = 1'b1;

        // Basic burst
        do_start(8'h10, 9'd4, 1'b1);
        wait_done("burst_10", 50);
        check("burst_10_done_count", done_count, 1);

        // Address wrap
        do_start(8'hFE, 9'd3, 1'b1);
        wait_done("wrap", 50);

        // Backpressure: 10 stall cycles, at most 2 reads outstanding
        out_ready = 1'b0;
        r0 = reads_issued;
        do_start(8'h20, 9'd8, 1'b1);
        repeat (10) @(negedge clk);
        check("stall_reads_le2", 32'((reads_issued - r0) <= 2), 1);
        check("stall_valid_high", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("stall", 200);

        // Side write during a stalled burst
        out_ready = 1'b0;
        g0 = grants;
        wr_req = 1'b1;
        wr_addr = 8'h80;
        wr_data = 8'h5A;
        do_start(8'h30, 9'd4, 1'b1);
        repeat (6) @(negedge clk);
        check("write_granted", 32'(grants > g0), 1);
        check("write_landed", mem[8'h80], 8'h5A);
        @(posedge clk); #1;
        wr_req = 1'b0;
        out_ready = 1'b1;
        wait_done("write", 200);

        // Zero-length burst
        d0 = done_count;
        r0 = reads_issued;
        do_start(8'h00, 9'd0, 1'b0);
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_done_once", done, 0);
        repeat (3) @(negedge clk);
        check("zero_no_reads", reads_issued - r0, 0);
        check("zero_done_count", done_count - d0, 1);

        // Start while busy is ignored
        d0 = done_count;
        do_start(8'h40, 9'd3, 1'b1);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 8'h90;
        count = 9'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start", 100);
        repeat (3) @(negedge clk);
        check("busy_start_done_count", done_count - d0, 1);
        check("busy_start_idle", busy, 0);

        // Reset mid-burst
        out_ready = 1'b0;
        do_start(8'h50, 9'd8, 1'b1);
        repeat (4) @(negedge clk);
        d0 = done_count;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_q.delete();
        addr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("midreset_no_done", done_count - d0, 0);
        check("midreset_idle", busy, 0);
        check("midreset_empty", out_valid, 0);

        // Recovery burst
        do_start(8'h05, 9'd2, 1'b1);
        wait_done("recover", 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
